// File: rtl/line_pingpong_buffer.sv
// Ping-pong line store: one page is filled while the other is read out.
// Define LINE_BUF_OUTREG_EN to add an output register on RAM read data.
module line_pingpong_buffer #(
  parameter int C_ADDR_W    = 9,
  parameter int D_WIDTH     = 10,
  parameter int LINE_PIXELS = 250
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               PULSE,
  input  logic [D_WIDTH-1:0] PIX_DATA,
  input  logic               PIXEL_ERROR,
  input  logic               LINE_SYNC,
  input  logic               FRAME_SYNC,
  output logic [D_WIDTH-1:0] RD_DATA,
  output logic               RDAT_VALID,
  output logic               H_SYNC,
  output logic               V_SYNC,
  output logic               LINE_FINISHED,
  output logic               RD_PAGE,
  output logic               OVERRUN
);

  localparam int P_AW    = C_ADDR_W - 1;
  localparam int P_DEPTH = 1 << C_ADDR_W;
  localparam logic [P_AW-1:0] P_LAST = P_AW'(LINE_PIXELS - 1);
  localparam logic [P_AW-1:0] P_MAX  = '1;

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  logic [D_WIDTH-1:0]  r_mem [P_DEPTH];
  logic [P_AW-1:0]     r_wr_addr;
  logic                r_wr_page;
  logic                r_wr_full;
  logic                r_line_bad;
  logic                r_rd_page;
  logic                r_line_fin;
  state_t              r_state;
  logic [P_AW-1:0]     r_rd_addr;
  logic                r_pend;
  logic                r_overrun;
  logic                r_vsync;
  logic                r_vld1;
  logic [D_WIDTH-1:0]  r_ram_q;

  logic                w_we;
  logic                w_bad;
  logic                w_issue;
  logic                w_last;
  logic [C_ADDR_W-1:0] w_waddr;
  logic [C_ADDR_W-1:0] w_raddr;

  assign w_we    = PULSE & ~r_wr_full;
  assign w_bad   = r_line_bad | PIXEL_ERROR;
  assign w_issue = (r_state == S_READ);
  assign w_last  = (r_rd_addr == P_LAST);
  assign w_waddr = {r_wr_page, r_wr_addr};
  assign w_raddr = {r_rd_page, r_rd_addr};

  always_ff @(posedge CLOCK) begin
    if (w_we) r_mem[w_waddr] <= PIX_DATA;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_ram_q <= '0;
      r_vld1  <= 1'b0;
    end else begin
      r_ram_q <= r_mem[w_raddr];
      r_vld1  <= w_issue;
    end
  end

  // A pixel on the LINE_SYNC cycle lands in the old page before the swap.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_wr_addr  <= '0;
      r_wr_page  <= 1'b0;
      r_wr_full  <= 1'b0;
      r_line_bad <= 1'b0;
      r_rd_page  <= 1'b0;
      r_line_fin <= 1'b0;
    end else begin
      r_line_fin <= 1'b0;
      if (FRAME_SYNC) begin
        r_wr_addr  <= '0;
        r_wr_page  <= 1'b0;
        r_wr_full  <= 1'b0;
        r_line_bad <= 1'b0;
      end else if (LINE_SYNC) begin
        if (!w_bad) begin
          r_rd_page  <= r_wr_page;
          r_wr_page  <= ~r_wr_page;
          r_line_fin <= 1'b1;
        end
        r_wr_addr  <= '0;
        r_wr_full  <= 1'b0;
        r_line_bad <= 1'b0;
      end else begin
        if (w_we) begin
          r_wr_addr <= r_wr_addr + 1'b1;
          if (r_wr_addr == P_MAX) r_wr_full <= 1'b1;
        end
        if (PIXEL_ERROR) r_line_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_pend    <= 1'b0;
      r_overrun <= 1'b0;
      r_vsync   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (FRAME_SYNC) begin
        r_state   <= S_IDLE;
        r_rd_addr <= '0;
        r_pend    <= 1'b0;
        r_vsync   <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (r_line_fin) begin
              r_state   <= S_READ;
              r_rd_addr <= '0;
              r_vsync   <= 1'b0;
            end
          end
          S_READ: begin
            if (w_last) begin
              // Back-to-back restart keeps the valid burst gap-free.
              if (r_pend || r_line_fin) begin
                r_rd_addr <= '0;
                r_pend    <= r_pend & r_line_fin;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
              if (r_line_fin) begin
                if (r_pend) r_overrun <= 1'b1;
                else        r_pend    <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

`ifdef LINE_BUF_OUTREG_EN
  logic               r_vld2;
  logic [D_WIDTH-1:0] r_dat2;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_vld2 <= 1'b0;
      r_dat2 <= '0;
    end else begin
      r_vld2 <= r_vld1;
      r_dat2 <= r_ram_q;
    end
  end

  assign RD_DATA    = r_dat2;
  assign RDAT_VALID = r_vld2;
  assign H_SYNC     = r_vld2;
`else
  assign RD_DATA    = r_ram_q;
  assign RDAT_VALID = r_vld1;
  assign H_SYNC     = r_vld1;
`endif

  assign V_SYNC        = r_vsync;
  assign LINE_FINISHED = r_line_fin;
  assign RD_PAGE       = r_rd_page;
  assign OVERRUN       = r_overrun;

endmodule

// File: tb/tb_line_pingpong_buffer.sv
// Bench for line_pingpong_buffer: control table, directed corners,
// random lines against a page/queue reference model.
`timescale 1ns/1ps
module tb_line_pingpong_buffer;

  localparam int AW = 9;
  localparam int DW = 10;
  localparam int LP = 250;
  localparam int PG = 256;
`ifdef LINE_BUF_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse = 1'b0;
  logic [DW-1:0] pix = '0;
  logic          err = 1'b0;
  logic          lsync = 1'b0;
  logic          fsync = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rdat_valid;
  logic          h_sync;
  logic          v_sync;
  logic          line_fin;
  logic          rd_page;
  logic          overrun;

  always #5 clk = ~clk;

  line_pingpong_buffer #(
    .C_ADDR_W   (AW),
    .D_WIDTH    (DW),
    .LINE_PIXELS(LP)
  ) dut (
    .CLOCK        (clk),
    .RESET        (rst_n),
    .PULSE        (pulse),
    .PIX_DATA     (pix),
    .PIXEL_ERROR  (err),
    .LINE_SYNC    (lsync),
    .FRAME_SYNC   (fsync),
    .RD_DATA      (rd_data),
    .RDAT_VALID   (rdat_valid),
    .H_SYNC       (h_sync),
    .V_SYNC       (v_sync),
    .LINE_FINISHED(line_fin),
    .RD_PAGE      (rd_page),
    .OVERRUN      (overrun)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: two pixel pages plus a queue of timed output words.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } exp_t;

  logic [DW-1:0] m [2][PG];
  int   wp = 0;
  int   wa = 0;
  int   rp = 0;
  bit   bad = 0;
  bit   mb;
  int   cyc = 0;
  int   lf_due = -1;
  exp_t xq[$];
  bit   chk_en = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      wp = 0; wa = 0; rp = 0; bad = 0;
      xq.delete();
    end else begin
      mb = bad | err;
      if (pulse && wa < PG) begin
        m[wp][wa] = pix;
        wa++;
      end
      if (fsync) begin
        wp = 0; wa = 0; bad = 0;
      end else if (lsync) begin
        if (!mb) begin
          rp = wp;
          for (int i = 0; i < LP; i++)
            xq.push_back('{cyc + LAT + i, m[wp][i]});
          lf_due = cyc;
          wp ^= 1;
        end
        wa = 0; bad = 0;
      end else if (err) begin
        bad = 1;
      end
    end
  end

  bit            ev;
  logic [DW-1:0] ed;

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      ev = 0; ed = '0;
      if (xq.size() > 0 && xq[0].due == cyc) begin
        ev = 1;
        ed = xq[0].d;
        void'(xq.pop_front());
      end
      chk("valid", int'(rdat_valid), int'(ev));
      chk("hsync", int'(h_sync), int'(ev));
      if (ev) chk("data", int'(rd_data), int'(ed));
      chk("line_fin", int'(line_fin), int'(lf_due == cyc));
      chk("rd_page", int'(rd_page), rp);
      chk("overrun", int'(overrun), 0);
    end else begin
      while (xq.size() > 0 && xq[0].due <= cyc) void'(xq.pop_front());
    end
  end

  task automatic step(input bit p, input logic [DW-1:0] d,
                      input bit e, input bit l, input bit f);
    @(posedge clk); #1;
    pulse = p; pix = d; err = e; lsync = l; fsync = f;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, 0, 0);
  endtask

  task automatic do_lsync();
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
  endtask

  task automatic wr_line(input int n, input int mode, input int errpos);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      case (mode)
        0:       d = DW'(i);
        1:       d = DW'(10'h3FF - i);
        default: d = DW'($urandom);
      endcase
      if (mode == 2 && $urandom_range(0, 3) == 0) step(0, '0, 0, 0, 0);
      step(1, d, (i == errpos), 0, 0);
    end
    step(0, '0, 0, 0, 0);
  endtask

  typedef struct {
    bit p, e, l, f;
    bit xlf, xrp, xvs, xov;
  } vec_t;

  vec_t tv[13];

  initial begin
    int cnt;
    int g;
    int vc;
    int run;
    int maxrun;
    int oc;

    tv[0]  = '{0,0,0,0, 0,0,0,0};
    tv[1]  = '{0,0,0,1, 0,0,1,0};
    tv[2]  = '{1,1,0,0, 0,0,1,0};
    tv[3]  = '{0,0,1,0, 0,0,1,0};
    tv[4]  = '{0,0,0,0, 0,0,1,0};
    tv[5]  = '{0,0,1,0, 1,0,1,0};
    tv[6]  = '{0,0,0,0, 0,0,0,0};
    tv[7]  = '{0,0,1,0, 1,1,0,0};
    tv[8]  = '{0,0,1,0, 1,0,0,0};
    tv[9]  = '{0,0,0,0, 0,0,0,1};
    tv[10] = '{0,0,0,0, 0,0,0,0};
    tv[11] = '{0,0,0,1, 0,0,1,0};
    tv[12] = '{0,0,0,0, 0,0,1,0};

    #3;
    chk("rst_data", int'(rd_data), 0);
    chk("rst_valid", int'(rdat_valid), 0);
    chk("rst_hsync", int'(h_sync), 0);
    chk("rst_vsync", int'(v_sync), 0);
    chk("rst_lf", int'(line_fin), 0);
    chk("rst_page", int'(rd_page), 0);
    chk("rst_ovr", int'(overrun), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      pulse = tv[i].p; pix = '0; err = tv[i].e;
      lsync = tv[i].l; fsync = tv[i].f;
      @(posedge clk); #1;
      chk($sformatf("tv%0d_lf", i), int'(line_fin), int'(tv[i].xlf));
      chk($sformatf("tv%0d_page", i), int'(rd_page), int'(tv[i].xrp));
      chk($sformatf("tv%0d_vsync", i), int'(v_sync), int'(tv[i].xvs));
      chk($sformatf("tv%0d_ovr", i), int'(overrun), int'(tv[i].xov));
    end
    idle(5);

    // ping-pong: B written into the other page during A's read-out
    xq.delete();
    chk_en = 1;
    wr_line(LP, 0, -1);
    do_lsync();
    wr_line(LP, 1, -1);
    idle(20);
    do_lsync();
    idle(270);

    // single line, overflow, bad line
    wr_line(LP, 0, -1);
    do_lsync();
    idle(270);
    wr_line(300, 0, -1);
    do_lsync();
    idle(270);
    wr_line(LP, 0, 50);
    do_lsync();
    idle(270);

    // frame sync mid read-out
    chk_en = 0;
    wr_line(LP, 0, -1);
    do_lsync();
    cnt = 0; g = 0;
    while (cnt < 100 && g < 600) begin
      @(posedge clk); #1;
      if (rdat_valid) cnt++;
      g++;
    end
    chk("fs_reach", cnt, 100);
    fsync = 1'b1;
    @(posedge clk); #1;
    fsync = 1'b0;
    chk("fs_vsync_set", int'(v_sync), 1);
    repeat (LAT - 1) begin
      @(posedge clk); #1;
    end
    chk("fs_valid_drop", int'(rdat_valid), 0);
    chk("fs_hsync_drop", int'(h_sync), 0);
    idle(20);
    chk("fs_vsync_hold", int'(v_sync), 1);
    chk("fs_quiet", int'(rdat_valid), 0);
    xq.delete();
    chk_en = 1;
    wr_line(LP, 1, -1);
    lsync = 1'b1;
    @(posedge clk); #1;
    lsync = 1'b0;
    chk("fs_vsync_pre", int'(v_sync), 1);
    chk("fs_page0", int'(rd_page), 0);
    @(posedge clk); #1;
    chk("fs_vsync_fall", int'(v_sync), 0);
    idle(270);

    // asynchronous reset mid read-out
    chk_en = 0;
    wr_line(LP, 2, -1);
    do_lsync();
    cnt = 0; g = 0;
    while (cnt < 50 && g < 600) begin
      @(posedge clk); #1;
      if (rdat_valid) cnt++;
      g++;
    end
    chk("rr_reach", cnt, 50);
    chk("rr_page_pre", int'(rd_page), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_data", int'(rd_data), 0);
    chk("rr_valid", int'(rdat_valid), 0);
    chk("rr_hsync", int'(h_sync), 0);
    chk("rr_vsync", int'(v_sync), 0);
    chk("rr_lf", int'(line_fin), 0);
    chk("rr_page", int'(rd_page), 0);
    chk("rr_ovr", int'(overrun), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (rdat_valid || h_sync || line_fin) cnt++;
    end
    chk("rr_quiet", cnt, 0);

    // three LINE_SYNCs 10 cycles apart
    vc = 0; run = 0; maxrun = 0; oc = 0;
    lsync = 1'b1;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk); #1;
      lsync = (c == 9 || c == 19);
      if (rdat_valid) begin
        vc++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (overrun) oc++;
    end
    chk("b2b_valid", vc, 2 * LP);
    chk("b2b_run", maxrun, 2 * LP);
    chk("b2b_overrun", oc, 1);
    idle(5);

    // random lines, gaps, overflow and bad pixels
    xq.delete();
    chk_en = 1;
    for (int l = 0; l < 12; l++) begin
      int n;
      int ep;
      n  = $urandom_range(240, 300);
      ep = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      wr_line(n, 2, ep);
      idle(15);
      do_lsync();
    end
    idle(270);
    chk("drain", xq.size(), 0);
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
